// File: rtl/tlp_rx_dispatcher_if.sv
// Dispatcher bundle: inbound TLP dword stream plus the bridge-facing request and buffer signals.
// master = dispatcher side, slave = stream source and APB bridge side.
interface tlp_rx_dispatcher_if;
    logic        RX_VALID;
    logic        RX_READY;
    logic [31:0] RX_DATA;
    logic        RX_SOP;
    logic        RX_EOP;
    logic        PENABLE;
    logic        PREADY;
    logic [2:0]  tlp_mem_io_msg_cpl_conf;
    logic        tlp_address_32_64;
    logic        tlp_read_write;
    logic [3:0]  first_dw_be;
    logic [3:0]  last_dw_be;
    logic [31:0] lower_addr;
    logic [11:0] config_dw_number;
    logic [7:0]  tlp_tag;
    logic [15:0] tlp_requester_id;
    logic [31:0] data;
    logic        last_dw;
    logic        DATA_BUFF_EMPTY;
    logic        DATA_BUFF_RD_EN;
    logic        RX_ERR;
    logic [15:0] DROP_COUNT;

    modport master (
        input  RX_VALID, RX_DATA, RX_SOP, RX_EOP, PREADY, DATA_BUFF_RD_EN,
        output RX_READY, PENABLE, tlp_mem_io_msg_cpl_conf, tlp_address_32_64,
               tlp_read_write, first_dw_be, last_dw_be, lower_addr, config_dw_number,
               tlp_tag, tlp_requester_id, data, last_dw, DATA_BUFF_EMPTY, RX_ERR, DROP_COUNT
    );

    modport slave (
        output RX_VALID, RX_DATA, RX_SOP, RX_EOP, PREADY, DATA_BUFF_RD_EN,
        input  RX_READY, PENABLE, tlp_mem_io_msg_cpl_conf, tlp_address_32_64,
               tlp_read_write, first_dw_be, last_dw_be, lower_addr, config_dw_number,
               tlp_tag, tlp_requester_id, data, last_dw, DATA_BUFF_EMPTY, RX_ERR, DROP_COUNT
    );
endinterface

// File: rtl/tlp_rx_dispatcher.sv
// Decodes inbound MEM/CONF TLPs, buffers the payload and hands them to the APB bridge.
// Define RX_DROP_CNT_EN to build the saturating dropped-TLP counter on DROP_COUNT.
//
// state      | meaning
// S_IDLE     | waiting for an SOP dword
// S_HDR      | collecting DW1..DW2 (3DW) or DW1..DW3 (4DW)
// S_PAYLOAD  | buffering write payload, down-counting remaining dwords
// S_DISPATCH | PENABLE high, fields held, waiting for PREADY
// S_DROP     | discarding dwords up to EOP
module tlp_rx_dispatcher #(
    parameter int DATA_DEPTH = 16
) (
    input logic                 PCLK,
    input logic                 PRESET,
    tlp_rx_dispatcher_if.master bus
);
    localparam int          AW      = $clog2(DATA_DEPTH);
    localparam logic [10:0] MAX_LEN = 11'(DATA_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DISPATCH, S_DROP} state_t;

    state_t      state;
    logic        rx_ready;
    logic        penable;
    logic        rx_err;
    logic [2:0]  tlp_type;
    logic        addr_64;
    logic        is_write;
    logic        type_ok;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [29:0] addr_dw;
    logic [9:0]  cfg_dw;
    logic [7:0]  tag;
    logic [15:0] req_id;
    logic [10:0] len_left;
    logic [1:0]  hdr_idx;

    logic [32:0] buf_mem [DATA_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        buf_empty;
    logic [32:0] buf_head;

    logic [31:0] rx_dw;
    logic        rx_eop;
    logic        rx_fire;
    logic        hdr_last;
    logic        dw0_mem;
    logic        dw0_conf;

    assign rx_dw     = bus.RX_DATA;
    assign rx_eop    = bus.RX_EOP;
    assign rx_fire   = bus.RX_VALID & rx_ready;
    assign dw0_mem   = rx_dw[28:24] == 5'b00000;
    assign dw0_conf  = rx_dw[28:25] == 4'b0010;
    assign hdr_last  = hdr_idx == (addr_64 ? 2'd3 : 2'd2);
    assign buf_empty = wr_ptr == rd_ptr;
    assign buf_head  = buf_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= S_IDLE;
            rx_ready <= 1'b0;
            penable  <= 1'b0;
            rx_err   <= 1'b0;
            tlp_type <= 3'd0;
            addr_64  <= 1'b0;
            is_write <= 1'b0;
            type_ok  <= 1'b0;
            fbe      <= 4'd0;
            lbe      <= 4'd0;
            addr_dw  <= 30'd0;
            cfg_dw   <= 10'd0;
            tag      <= 8'd0;
            req_id   <= 16'd0;
            len_left <= 11'd0;
            hdr_idx  <= 2'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            rx_err <= 1'b0;
            if (bus.DATA_BUFF_RD_EN && !buf_empty)
                rd_ptr <= rd_ptr + 1'b1;
            // flush assignments below are placed after the pop so they take precedence
            case (state)
                S_IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire && bus.RX_SOP) begin
                        addr_64  <= rx_dw[29];
                        is_write <= rx_dw[30];
                        type_ok  <= dw0_mem | dw0_conf;
                        tlp_type <= dw0_conf ? 3'd4 : 3'd0;
                        len_left <= {rx_dw[9:0] == 10'd0, rx_dw[9:0]};
                        hdr_idx  <= 2'd1;
                        if (rx_eop)
                            rx_err <= 1'b1;
                        else
                            state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (rx_fire) begin
                        if (bus.RX_SOP) begin
                            rx_err <= 1'b1;
                            state  <= rx_eop ? S_IDLE : S_DROP;
                        end else begin
                            hdr_idx <= hdr_idx + 2'd1;
                            case (hdr_idx)
                                2'd1: begin
                                    req_id <= rx_dw[31:16];
                                    tag    <= rx_dw[15:8];
                                    lbe    <= rx_dw[7:4];
                                    fbe    <= rx_dw[3:0];
                                end
                                2'd2: begin
                                    cfg_dw <= rx_dw[11:2];
                                    if (!addr_64)
                                        addr_dw <= rx_dw[31:2];
                                end
                                default: addr_dw <= rx_dw[31:2];
                            endcase
                            if (!hdr_last) begin
                                if (rx_eop) begin
                                    rx_err <= 1'b1;
                                    state  <= S_IDLE;
                                end
                            end else if (!type_ok || (is_write && (len_left > MAX_LEN || rx_eop))) begin
                                rx_err <= 1'b1;
                                state  <= rx_eop ? S_IDLE : S_DROP;
                            end else if (!is_write) begin
                                if (rx_eop) begin
                                    // bridge needs a non-empty buffer even for reads
                                    buf_mem[wr_ptr[AW-1:0]] <= {1'b1, 32'h0};
                                    wr_ptr   <= wr_ptr + 1'b1;
                                    penable  <= 1'b1;
                                    rx_ready <= 1'b0;
                                    state    <= S_DISPATCH;
                                end else begin
                                    rx_err <= 1'b1;
                                    state  <= S_DROP;
                                end
                            end else begin
                                state <= S_PAYLOAD;
                            end
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_fire) begin
                        if (bus.RX_SOP || (rx_eop != (len_left == 11'd1))) begin
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                            rx_err <= 1'b1;
                            state  <= rx_eop ? S_IDLE : S_DROP;
                        end else begin
                            buf_mem[wr_ptr[AW-1:0]] <= {len_left == 11'd1, rx_dw};
                            wr_ptr   <= wr_ptr + 1'b1;
                            len_left <= len_left - 11'd1;
                            if (rx_eop) begin
                                penable  <= 1'b1;
                                rx_ready <= 1'b0;
                                state    <= S_DISPATCH;
                            end
                        end
                    end
                end
                S_DISPATCH: begin
                    if (bus.PREADY) begin
                        penable  <= 1'b0;
                        rx_ready <= 1'b1;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        state    <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (rx_fire && rx_eop)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RX_DROP_CNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge PCLK) begin
        if (PRESET)
            drop_cnt <= 16'd0;
        else if (rx_err && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end

    assign bus.DROP_COUNT = drop_cnt;
`else
    assign bus.DROP_COUNT = 16'h0000;
`endif

    assign bus.RX_READY                = rx_ready;
    assign bus.PENABLE                 = penable;
    assign bus.RX_ERR                  = rx_err;
    assign bus.tlp_mem_io_msg_cpl_conf = tlp_type;
    assign bus.tlp_address_32_64       = addr_64;
    assign bus.tlp_read_write          = is_write;
    assign bus.first_dw_be             = fbe;
    assign bus.last_dw_be              = lbe;
    assign bus.lower_addr              = {addr_dw, 2'b00};
    assign bus.config_dw_number        = {cfg_dw, 2'b00};
    assign bus.tlp_tag                 = tag;
    assign bus.tlp_requester_id        = req_id;
    assign bus.data                    = buf_empty ? 32'h0 : buf_head[31:0];
    assign bus.last_dw                 = !buf_empty && buf_head[32];
    assign bus.DATA_BUFF_EMPTY         = buf_empty;
endmodule

// File: tb/tb_tlp_rx_dispatcher.sv
// Scoreboard bench for tlp_rx_dispatcher: expected dispatches are queued as TLPs are sent
// and compared when PENABLE rises; drops are checked against an RX_ERR pulse model.
module tb_tlp_rx_dispatcher;
    logic PCLK = 1'b0;
    logic PRESET;

    tlp_rx_dispatcher_if bus();

    tlp_rx_dispatcher #(.DATA_DEPTH(16)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [2:0]  typ;
        logic        rw;
        logic        a64;
        logic [31:0] addr;
        logic [11:0] cfg;
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [3:0]  fbe;
        logic [3:0]  lbe;
        logic [7:0]  n;
    } exp_t;

    exp_t        hq[$];
    logic [32:0] dq[$];
    logic [31:0] pkt[$];

    int n_cmp = 0;
    int n_bad = 0;
    int err_pulses = 0;
    int exp_err = 0;
    int pen_rises = 0;
    int n_disp = 0;
    int stalls = 0;
    logic pen_q = 1'b0;

    always @(posedge PCLK) begin
        if (bus.RX_ERR) err_pulses++;
        if (bus.PENABLE && !pen_q) pen_rises++;
        pen_q = bus.PENABLE;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_dw(input logic [31:0] d, input logic sop, input logic eop);
        int n = 0;
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = d;
        bus.RX_SOP   = sop;
        bus.RX_EOP   = eop;
        while (!bus.RX_READY && n < 100) begin
            @(posedge PCLK); #1;
            n++;
        end
        stalls += n;
        if (n >= 100) chk("rx_ready_timeout", 32'(bus.RX_READY), 32'd1);
        @(posedge PCLK); #1;
        bus.RX_VALID = 1'b0;
        bus.RX_SOP   = 1'b0;
        bus.RX_EOP   = 1'b0;
    endtask

    // eop_idx < 0 : EOP on the last queued dword; otherwise stop early with EOP there
    task automatic send_pkt(input int eop_idx);
        int last;
        last = (eop_idx < 0) ? pkt.size() - 1 : eop_idx;
        for (int i = 0; i <= last; i++)
            send_dw(pkt[i], i == 0, i == last);
        pkt.delete();
    endtask

    task automatic serve();
        exp_t        e;
        logic [32:0] x;
        int          n = 0;
        while (!bus.PENABLE && n < 50) begin
            @(posedge PCLK); #1;
            n++;
        end
        chk("penable_latency", 32'(n), 32'd0);
        n_disp++;
        if (hq.size() == 0) begin
            chk("hq_nonempty", 32'(hq.size()), 32'd1);
            return;
        end
        e = hq.pop_front();
        if (!bus.PENABLE) begin
            for (int i = 0; i < int'(e.n); i++) void'(dq.pop_front());
            return;
        end
        chk("rx_ready_dispatch", 32'(bus.RX_READY), 32'd0);
        chk("type", 32'(bus.tlp_mem_io_msg_cpl_conf), 32'(e.typ));
        chk("read_write", 32'(bus.tlp_read_write), 32'(e.rw));
        chk("addr_32_64", 32'(bus.tlp_address_32_64), 32'(e.a64));
        chk("lower_addr", bus.lower_addr, e.addr);
        chk("config_dw_number", 32'(bus.config_dw_number), 32'(e.cfg));
        chk("tag", 32'(bus.tlp_tag), 32'(e.tag));
        chk("requester_id", 32'(bus.tlp_requester_id), 32'(e.rid));
        chk("first_dw_be", 32'(bus.first_dw_be), 32'(e.fbe));
        chk("last_dw_be", 32'(bus.last_dw_be), 32'(e.lbe));
        for (int i = 0; i < int'(e.n); i++) begin
            x = dq.pop_front();
            chk("empty_mid", 32'(bus.DATA_BUFF_EMPTY), 32'd0);
            chk("data", bus.data, x[31:0]);
            chk("last_dw", 32'(bus.last_dw), 32'(x[32]));
            bus.DATA_BUFF_RD_EN = 1'b1;
            @(posedge PCLK); #1;
            bus.DATA_BUFF_RD_EN = 1'b0;
        end
        chk("empty_after_pops", 32'(bus.DATA_BUFF_EMPTY), 32'd1);
        chk("data_when_empty", bus.data, 32'd0);
        chk("penable_held", 32'(bus.PENABLE), 32'd1);
        bus.PREADY = 1'b1;
        @(posedge PCLK); #1;
        bus.PREADY = 1'b0;
        chk("penable_after_pready", 32'(bus.PENABLE), 32'd0);
        chk("rx_ready_after_pready", 32'(bus.RX_READY), 32'd1);
    endtask

    task automatic check_drop(input string tag);
        repeat (3) @(posedge PCLK);
        #1;
        chk({tag, "_rx_err_pulses"}, 32'(err_pulses), 32'(exp_err));
        chk({tag, "_penable"}, 32'(bus.PENABLE), 32'd0);
        chk({tag, "_empty"}, 32'(bus.DATA_BUFF_EMPTY), 32'd1);
        chk({tag, "_rx_ready"}, 32'(bus.RX_READY), 32'd1);
`ifdef RX_DROP_CNT_EN
        chk({tag, "_drop_count"}, 32'(bus.DROP_COUNT), 32'(exp_err));
`else
        chk({tag, "_drop_count"}, 32'(bus.DROP_COUNT), 32'd0);
`endif
    endtask

    initial begin
        PRESET              = 1'b1;
        bus.RX_VALID        = 1'b0;
        bus.RX_DATA         = 32'h0;
        bus.RX_SOP          = 1'b0;
        bus.RX_EOP          = 1'b0;
        bus.PREADY          = 1'b0;
        bus.DATA_BUFF_RD_EN = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_rx_ready", 32'(bus.RX_READY), 32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_empty", 32'(bus.DATA_BUFF_EMPTY), 32'd1);
        chk("rst_data", bus.data, 32'd0);
        chk("rst_last_dw", 32'(bus.last_dw), 32'd0);
        chk("rst_rx_err", 32'(bus.RX_ERR), 32'd0);
        chk("rst_lower_addr", bus.lower_addr, 32'd0);
        chk("rst_drop_count", 32'(bus.DROP_COUNT), 32'd0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        chk("rx_ready_after_rst", 32'(bus.RX_READY), 32'd1);

        // 3DW MemWr, Length 2
        pkt = '{32'h4000_0002, 32'h0100_053F, 32'h0000_1000, 32'h0000_000A, 32'h0000_000B};
        hq.push_back('{typ: 3'd0, rw: 1'b1, a64: 1'b0, addr: 32'h1000, cfg: 12'h000,
                       tag: 8'h05, rid: 16'h0100, fbe: 4'hF, lbe: 4'h3, n: 8'd2});
        dq.push_back({1'b0, 32'h0000_000A});
        dq.push_back({1'b1, 32'h0000_000B});
        send_pkt(-1);
        serve();

        // 4DW MemRd
        pkt = '{32'h2000_0001, 32'hABCD_770F, 32'h0000_0001, 32'h0000_2004};
        hq.push_back('{typ: 3'd0, rw: 1'b0, a64: 1'b1, addr: 32'h2004, cfg: 12'h000,
                       tag: 8'h77, rid: 16'hABCD, fbe: 4'hF, lbe: 4'h0, n: 8'd1});
        dq.push_back({1'b1, 32'h0});
        send_pkt(-1);
        serve();

        // CfgWr0
        pkt = '{32'h4400_0001, 32'h0010_2A0F, 32'h0000_0304, 32'h0000_DEAD};
        hq.push_back('{typ: 3'd4, rw: 1'b1, a64: 1'b0, addr: 32'h0304, cfg: 12'h304,
                       tag: 8'h2A, rid: 16'h0010, fbe: 4'hF, lbe: 4'h0, n: 8'd1});
        dq.push_back({1'b1, 32'h0000_DEAD});
        send_pkt(-1);
        serve();

        // MemWr Length 17 exceeds the buffer
        pkt = '{32'h4000_0011, 32'h0200_11FF, 32'h0000_5000};
        for (int i = 0; i < 17; i++) pkt.push_back(32'h100 + 32'(i));
        exp_err++;
        send_pkt(-1);
        chk("len17_no_stall", 32'(stalls), 32'd0);
        check_drop("len17");

        // MemWr Length 4 with EOP on payload dword 2, then a clean MemWr
        pkt = '{32'h4000_0004, 32'h0300_22FF, 32'h0000_6000, 32'h1111_1111, 32'h2222_2222};
        exp_err++;
        send_pkt(4);
        check_drop("early_eop");
        pkt = '{32'h4000_0001, 32'h0300_23C1, 32'h0000_6100, 32'h3333_3333};
        hq.push_back('{typ: 3'd0, rw: 1'b1, a64: 1'b0, addr: 32'h6100, cfg: 12'h100,
                       tag: 8'h23, rid: 16'h0300, fbe: 4'h1, lbe: 4'hC, n: 8'd1});
        dq.push_back({1'b1, 32'h3333_3333});
        send_pkt(-1);
        serve();

        // CplD is unsupported, then a clean 3DW MemRd
        pkt = '{32'h4A00_0001, 32'h0400_0004, 32'h0000_3300, 32'hCCCC_CCCC};
        exp_err++;
        send_pkt(-1);
        check_drop("cpl");
        pkt = '{32'h0000_0001, 32'h0500_4402, 32'h0000_4008};
        hq.push_back('{typ: 3'd0, rw: 1'b0, a64: 1'b0, addr: 32'h4008, cfg: 12'h008,
                       tag: 8'h44, rid: 16'h0500, fbe: 4'h2, lbe: 4'h0, n: 8'd1});
        dq.push_back({1'b1, 32'h0});
        send_pkt(-1);
        serve();

        // reset while dispatching
        pkt = '{32'h4000_0001, 32'h1234_560F, 32'h0000_3000, 32'h0000_0055};
        send_pkt(-1);
        chk("pre_reset_penable", 32'(bus.PENABLE), 32'd1);
        n_disp++;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        chk("mid_rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("mid_rst_empty", 32'(bus.DATA_BUFF_EMPTY), 32'd1);
        chk("mid_rst_rx_err", 32'(bus.RX_ERR), 32'd0);
        chk("mid_rst_drop_count", 32'(bus.DROP_COUNT), 32'd0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        chk("rx_ready_after_mid_rst", 32'(bus.RX_READY), 32'd1);
        repeat (2) @(posedge PCLK);
        #1;
        chk("mid_rst_no_err_pulse", 32'(err_pulses), 32'(exp_err));

        pkt = '{32'h0000_0001, 32'h0600_5501, 32'h0000_7010};
        hq.push_back('{typ: 3'd0, rw: 1'b0, a64: 1'b0, addr: 32'h7010, cfg: 12'h010,
                       tag: 8'h55, rid: 16'h0600, fbe: 4'h1, lbe: 4'h0, n: 8'd1});
        dq.push_back({1'b1, 32'h0});
        send_pkt(-1);
        serve();

        repeat (2) @(posedge PCLK);
        #1;
        chk("penable_rises", 32'(pen_rises), 32'(n_disp));
        chk("total_stalls", 32'(stalls), 32'd0);
        chk("rx_err_total", 32'(err_pulses), 32'(exp_err));
        chk("scoreboard_drained", 32'(hq.size() + dq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tlp_rx_dispatcher.md
# tlp_rx_dispatcher

- Receive-side stage directly upstream of the APB master bridge.
- Accepts inbound TLPs as a 32-bit dword stream, decodes the header, and stores the payload in a show-ahead dword buffer.
- Presents the decoded fields plus buffer to the bridge under a PENABLE/PREADY handshake.
- Drops TLP types the bridge cannot service, so the bridge never hangs on an unserviceable request.

## Interface
Parameters:
- DATA_DEPTH, 16, payload buffer depth in dwords (power of 2, ≥2); maximum accepted payload length.

Ports:
- PCLK  in  1  single clock; everything is on its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- RX_VALID  in  1  stream dword valid.
- RX_READY  out  1  stream dword accept; a transfer occurs when RX_VALID && RX_READY.
- RX_DATA  in  32  stream dword.
- RX_SOP / RX_EOP  in  1 each  first / last dword of the TLP.
- PENABLE  out  1  request to the bridge.
- PREADY  in  1  one-cycle completion pulse from the bridge.
- tlp_mem_io_msg_cpl_conf  out  3  0=MEM, 4=CONF; no other value is ever presented.
- tlp_address_32_64  out  1  Fmt[0]; 1 = 4DW header.
- tlp_read_write  out  1  Fmt[1]; 1 = write.
- first_dw_be / last_dw_be  out  4 each  DW1[3:0] / DW1[7:4].
- lower_addr  out  32  {addr[31:2],2'b00}; address taken from DW2 (3DW header) or DW3 (4DW header).
- config_dw_number  out  12  CONF byte address {ext_reg[3:0], reg[5:0], 2'b00} = {DW2[11:2], 2'b00}.
- tlp_tag  out  8  DW1[15:8].
- tlp_requester_id  out  16  DW1[31:16].
- data  out  32  buffer head; 0 when empty.
- last_dw  out  1  head entry is the final payload dword.
- DATA_BUFF_EMPTY  out  1  buffer empty.
- DATA_BUFF_RD_EN  in  1  pop head; ignored when empty.
- RX_ERR  out  1  one-cycle pulse when a TLP is dropped.
- DROP_COUNT  out  16  see Configuration.

## Operation
Type decode from DW0 Fmt[31:29] / Type[28:24] / Length[9:0]:
- Type 00000 → MEM (0).
- Type 0010x → CONF (4).
- Anything else (IO, MSG, CPL) → unsupported → drop.
- Length 0 means 1024 dwords.

States:
- IDLE: RX_READY=1. An accepted dword without SOP is discarded. An accepted dword with SOP latches DW0 → HDR.
- HDR: collects DW1..DW2 (3DW) or DW1..DW3 (4DW), latching fields. On the last header dword:
  - unsupported type, or write with Length > DATA_DEPTH → DROP.
  - EOP before the last header dword → DROP.
  - read → push one dummy entry (0, last=1), since the bridge needs a non-empty buffer to start. Requires EOP on this dword, else DROP.
  - write → PAYLOAD.
- PAYLOAD: each accepted dword is pushed with last=(count==Length).
  - EOP on the final dword → DISPATCH.
  - EOP early, or missing on the final dword → flush buffer → DROP.
- DISPATCH: RX_READY=0, PENABLE=1; all field outputs held stable. When PREADY is sampled 1: PENABLE=0 next cycle, buffer flushed → IDLE.
- DROP: RX_READY=1. Discards dwords up to and including EOP (immediately if the triggering dword carried EOP). RX_ERR pulses once on entry. → IDLE.

Other rules:
- A SOP seen in HDR/PAYLOAD is malformed → DROP; that dword is discarded.
- Store-and-forward: PENABLE rises only once the whole payload is buffered, so the bridge never sees a mid-payload empty. This means the buffer is never full during PAYLOAD.
- Buffer: circular pointers of log2(DATA_DEPTH)+1 bits (wrap bit distinguishes full from empty). Push and pop in the same cycle are both honoured.

## Timing
- Reset: state IDLE, buffer empty. RX_READY=0 during reset, 1 in the first cycle after. All other outputs 0; DATA_BUFF_EMPTY=1.
- PENABLE asserts the cycle after the EOP dword is accepted.
- Minimum TLP-to-TLP gap: PENABLE low for one cycle after PREADY, with RX_READY high from that same cycle.
- Reset mid-operation discards the in-flight TLP without an RX_ERR pulse.
- last_dw and data update the cycle after a pop.

## Configuration
- RX_DROP_CNT_EN defined: DROP_COUNT is a saturating (0xFFFF) count of RX_ERR pulses, cleared by PRESET.
- Undefined: DROP_COUNT is tied to 0 and no counter logic is built.

## Test plan
- 3DW MemWr, addr 0x1000, Length 2, BE F/3, data 0xA, 0xB:
  - PENABLE the cycle after EOP; type 0, rw 1, 32_64 0, lower_addr 0x1000.
  - Buffer holds 0xA (last 0), 0xB (last 1).
  - PREADY pulse → PENABLE 0 next cycle.
- 4DW MemRd, DW2 0x1, DW3 0x2004 → lower_addr 0x2004, 32_64 1, single entry data 0 with last_dw 1, EMPTY 0.
- CfgWr0, DW2 = 0x0000_0304 → type 4, config_dw_number 0x304; payload 0xDEAD with last_dw 1.
- MemWr Length 17 with DATA_DEPTH 16 → RX_ERR one pulse, no PENABLE, RX_READY 1 until EOP; DROP_COUNT = 1 with macro, 0 without.
- Malformed inputs → RX_ERR, buffer empty, back in IDLE, with a clean next TLP dispatched normally:
  - MemWr Length 4 with EOP on payload dword 2.
  - CPL TLP.
- PRESET asserted during DISPATCH → next cycle PENABLE 0, EMPTY 1, no RX_ERR.
